// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch slice.
package mips_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it in one cycle.
module mips_fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          wr_en, rd_en;
    fetch_entry_t  mem [DEPTH];

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign wr_en = push && !flush && (!full || pop);
    assign rd_en = pop && !empty && !flush;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem reads into a prefetch FIFO.
// Define MIPS_FETCH_STATS_EN to add fetch_count / discard_count outputs.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc
`ifdef MIPS_FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        discard_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   pc, rpc_al;
    logic [CW-1:0] fifo_count, occ_next;
    logic          fifo_full, fifo_empty;
    fetch_entry_t  head;
    logic          acked, push, pop, issue;

    assign rpc_al      = word_align(redirect_pc);
    assign instr_valid = !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign pop         = instr_valid && instr_ready;
    assign acked       = (state == WAIT) && imem_ack;
    assign push        = acked && !redirect;

    // Occupancy after this cycle's push/pop/flush decides whether to keep requesting.
    always_comb begin
        occ_next = fifo_count;
        if (redirect) occ_next = '0;
        else          occ_next = fifo_count + CW'(push) - CW'(pop);
    end
    assign issue = (occ_next < CW'(FIFO_DEPTH));

    mips_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ('{pc: pc, instr: imem_rdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc        <= rpc_al;
                        imem_addr <= rpc_al;
                        imem_req  <= 1'b1;
                        state     <= WAIT;
                    end else if (issue) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc <= rpc_al;
                        if (imem_ack) begin
                            imem_addr <= rpc_al;
                            imem_req  <= issue;
                            state     <= issue ? WAIT : IDLE;
                        end else begin
                            // Request must stay stable; its data is dropped on ack.
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc        <= pc + PC_STEP;
                        imem_addr <= pc + PC_STEP;
                        imem_req  <= issue;
                        state     <= issue ? WAIT : IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        pc        <= redirect ? rpc_al : pc;
                        imem_addr <= redirect ? rpc_al : pc;
                        state     <= WAIT;
                    end else if (redirect) begin
                        pc <= rpc_al;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIPS_FETCH_STATS_EN
    logic        drop;
    logic [32:0] fsum, dsum;

    assign drop = imem_ack && (((state == WAIT) && redirect) || (state == DISCARD));
    assign fsum = {1'b0, fetch_count} + 33'(acked);
    assign dsum = {1'b0, discard_count} + 33'({CW{redirect}} & fifo_count) + 33'(drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count   <= '0;
            discard_count <= '0;
        end else begin
            fetch_count   <= fsum[32] ? '1 : fsum[31:0];
            discard_count <= dsum[32] ? '1 : dsum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: vector table for streaming/backpressure,
// hand sequences for redirect, discard, wrap and mid-transaction reset.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] fetch_count, discard_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    mips_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef MIPS_FETCH_STATS_EN
        ,
        .fetch_count   (fetch_count),
        .discard_count (discard_count)
`endif
    );

    typedef struct {
        bit          ack, rdy, rdr;
        logic [31:0] rpc;
        bit          ereq;
        logic [31:0] eaddr;
        bit          evld;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " req"}, 32'(imem_req), 32'd0);
        chk({tag, " addr"}, imem_addr, 32'h0);
        chk({tag, " valid"}, 32'(instr_valid), 32'd0);
        chk({tag, " instr"}, instr, 32'h0);
        chk({tag, " instr_pc"}, instr_pc, 32'h0);
`ifdef MIPS_FETCH_STATS_EN
        chk({tag, " fetch_count"}, fetch_count, 32'h0);
        chk({tag, " discard_count"}, discard_count, 32'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(posedge clk); #1;
        reset_checks(tag);
        rst = 1'b1;
    endtask

    // Drive inputs for the coming edge, check registered outputs, advance one cycle.
    task automatic cyc(input string tag, input bit ack, input bit rdy, input bit rdr,
                       input logic [31:0] rpc, input bit ereq, input logic [31:0] eaddr,
                       input bit evld, input logic [31:0] epc);
        imem_ack = ack; instr_ready = rdy; redirect = rdr; redirect_pc = rpc;
        #1;
        chk({tag, " req"}, 32'(imem_req), 32'(ereq));
        if (ereq) chk({tag, " addr"}, imem_addr, eaddr);
        chk({tag, " valid"}, 32'(instr_valid), 32'(evld));
        if (evld) begin
            chk({tag, " instr_pc"}, instr_pc, epc);
            chk({tag, " instr"}, instr, mem_word(epc));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ack tied high: stream, then backpressure fills 4 entries and idles, then resume.
        tbl[0]  = '{1, 1, 0, 0, 0, 32'd0,  0, 32'd0};
        tbl[1]  = '{1, 1, 0, 0, 1, 32'd0,  0, 32'd0};
        tbl[2]  = '{1, 1, 0, 0, 1, 32'd4,  1, 32'd0};
        tbl[3]  = '{1, 1, 0, 0, 1, 32'd8,  1, 32'd4};
        tbl[4]  = '{1, 1, 0, 0, 1, 32'd12, 1, 32'd8};
        tbl[5]  = '{1, 0, 0, 0, 1, 32'd16, 1, 32'd12};
        tbl[6]  = '{1, 0, 0, 0, 1, 32'd20, 1, 32'd12};
        tbl[7]  = '{1, 0, 0, 0, 1, 32'd24, 1, 32'd12};
        tbl[8]  = '{1, 0, 0, 0, 0, 32'd0,  1, 32'd12};
        tbl[9]  = '{1, 1, 0, 0, 0, 32'd0,  1, 32'd12};
        tbl[10] = '{1, 1, 0, 0, 1, 32'd28, 1, 32'd16};
        tbl[11] = '{1, 1, 0, 0, 1, 32'd32, 1, 32'd20};
        tbl[12] = '{1, 1, 0, 0, 1, 32'd36, 1, 32'd24};
        tbl[13] = '{1, 1, 0, 0, 1, 32'd40, 1, 32'd28};

        @(posedge clk); #1;
        do_reset("rst0");
        for (int i = 0; i < 14; i++)
            cyc($sformatf("t%0d", i), tbl[i].ack, tbl[i].rdy, tbl[i].rdr, tbl[i].rpc,
                tbl[i].ereq, tbl[i].eaddr, tbl[i].evld, tbl[i].epc);

        // Slow ack with redirect mid-wait, then redirect with ack+pop, then PC wrap.
        do_reset("rst1");
        cyc("d0",  0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        cyc("d1",  0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
        cyc("d2",  0, 1, 1, 32'h0000_0103, 1, 32'h0,         0, 32'h0);
        cyc("d3",  0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
        cyc("d4",  1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
        cyc("d5",  1, 1, 0, 32'h0,         1, 32'h100,       0, 32'h0);
        cyc("d6",  1, 0, 0, 32'h0,         1, 32'h104,       1, 32'h100);
        cyc("d7",  1, 0, 0, 32'h0,         1, 32'h108,       1, 32'h100);
        cyc("d8",  1, 1, 1, 32'h200,       1, 32'h10C,       1, 32'h100);
        cyc("d9",  1, 1, 0, 32'h0,         1, 32'h200,       0, 32'h0);
        cyc("d10", 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h204,       1, 32'h200);
        cyc("d11", 1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
        cyc("d12", 1, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC);
        cyc("d13", 0, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0);

        // Back-to-back redirects while discarding: the last one wins.
        do_reset("rst2");
        cyc("r0", 0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        cyc("r1", 0, 1, 1, 32'h40, 1, 32'h0,  0, 32'h0);
        cyc("r2", 0, 1, 1, 32'h82, 1, 32'h0,  0, 32'h0);
        cyc("r3", 1, 1, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        cyc("r4", 1, 0, 0, 32'h0,  1, 32'h80, 0, 32'h0);
        cyc("r5", 0, 0, 0, 32'h0,  1, 32'h84, 1, 32'h80);

        // Asynchronous reset pulse mid-WAIT with a non-empty FIFO.
        rst = 1'b0;
        #1;
        reset_checks("async");
        @(posedge clk); #1;
        rst = 1'b1;
        cyc("a0", 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cyc("a1", 1, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0);
        cyc("a2", 1, 1, 0, 32'h0, 1, 32'h4, 1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
